// File: rtl/simon_seq_player.sv
// Simon sequence player: expands a latched seed into 2-bit colours and either plays
// them on one-hot LEDs with on/off timing or hands them out one per recall_req.
module simon_seq_player #(
    parameter int SEED_W     = 32,
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEED_W-1:0] seed,
    input  logic              seed_load,
    input  logic [4:0]        level,
    input  logic              play_start,
    input  logic              recall_start,
    input  logic              recall_req,
    output logic [1:0]        color,
    output logic              color_valid,
    output logic [3:0]        led,
    output logic              busy,
    output logic              done
);

    localparam int MAX_LEN = SEED_W / 2;
    localparam int IDX_W   = $clog2(MAX_LEN);
    localparam int TMAX    = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW      = $clog2(TMAX + 1);
    localparam logic [5:0] MAX_LEN6 = 6'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, ON, OFF, RECALL} state_t;

    state_t             state;
    logic [SEED_W-1:0]  seq_reg;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   len_m1;
    logic [TW-1:0]      timer;

    logic [IDX_W-1:0]   len_sel;
    logic [IDX_W-1:0]   idx_inc;
    logic [1:0]         start_col;
    logic [1:0]         next_col;
    logic [1:0]         cur_col;

    function automatic logic [1:0] step_of(input logic [SEED_W-1:0] s,
                                           input logic [IDX_W-1:0]  i);
        logic [SEED_W-1:0] t;
        t = s >> {i, 1'b0};
        return t[1:0];
    endfunction

    // Length is stored as len-1 so it fits the index width even at MAX_LEN.
    always_comb begin
        len_sel = '0;
        if (level == 5'd0)
            len_sel = '0;
        else if ({1'b0, level} > MAX_LEN6)
            len_sel = IDX_W'(MAX_LEN - 1);
        else
            len_sel = IDX_W'(level - 5'd1);
    end

    assign idx_inc   = idx + 1'b1;
    assign start_col = step_of(seed_load ? seed : seq_reg, '0);
    assign next_col  = step_of(seq_reg, idx_inc);
    assign cur_col   = step_of(seq_reg, idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            seq_reg     <= '0;
            idx         <= '0;
            len_m1      <= '0;
            timer       <= '0;
            color       <= '0;
            color_valid <= 1'b0;
            led         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            color_valid <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_load)
                        seq_reg <= seed;
                    if (play_start) begin
                        state  <= ON;
                        busy   <= 1'b1;
                        idx    <= '0;
                        len_m1 <= len_sel;
                        timer  <= TW'(ON_CYCLES - 1);
                        color  <= start_col;
                        led    <= 4'b0001 << start_col;
                    end else if (recall_start) begin
                        state  <= RECALL;
                        busy   <= 1'b1;
                        idx    <= '0;
                        len_m1 <= len_sel;
                    end
                end
                ON: begin
                    if (timer == '0) begin
                        state <= OFF;
                        led   <= '0;
                        timer <= TW'(OFF_CYCLES - 1);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                OFF: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (idx < len_m1) begin
                        state <= ON;
                        idx   <= idx_inc;
                        timer <= TW'(ON_CYCLES - 1);
                        color <= next_col;
                        led   <= 4'b0001 << next_col;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                RECALL: begin
                    // The done cycle is spent in RECALL so requests there are swallowed.
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (recall_req) begin
                        color_valid <= 1'b1;
                        color       <= cur_col;
                        if (idx == len_m1)
                            done <= 1'b1;
                        else
                            idx <= idx_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_seq_player.sv
// Randomised and directed bench for simon_seq_player against a cycle-count model.
module tb_simon_seq_player;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int P   = ON + OFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] seed;
    logic        seed_load;
    logic [4:0]  level;
    logic        play_start;
    logic        recall_start;
    logic        recall_req;
    logic [1:0]  color;
    logic        color_valid;
    logic [3:0]  led;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    simon_seq_player #(.SEED_W(32), .ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
        .clk(clk), .reset(reset), .seed(seed), .seed_load(seed_load), .level(level),
        .play_start(play_start), .recall_start(recall_start), .recall_req(recall_req),
        .color(color), .color_valid(color_valid), .led(led), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 play, 2 recall; play outputs derived from cycle count k.
    int          m_mode = 0;
    int          m_k, m_len, m_cnt;
    logic [31:0] m_seq = '0;
    logic [3:0]  exp_led = '0;
    logic [1:0]  exp_color = '0;
    logic        exp_cv = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

    function automatic logic [1:0] col_of(input logic [31:0] s, input int i);
        logic [31:0] t;
        t = s >> (2 * i);
        return t[1:0];
    endfunction

    function automatic int clamp_len(input logic [4:0] lv);
        if (lv == 0) return 1;
        if (lv > 16) return 16;
        return int'(lv);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_seq = '0;
            exp_led = '0; exp_color = '0; exp_cv = 0; exp_busy = 0; exp_done = 0;
        end else begin
            exp_cv = 0;
            exp_done = 0;
            case (m_mode)
                0: begin
                    if (seed_load) m_seq = seed;
                    if (play_start) begin
                        m_mode = 1; m_len = clamp_len(level); m_k = 0;
                    end else if (recall_start) begin
                        m_mode = 2; m_len = clamp_len(level); m_cnt = 0;
                    end
                end
                1: ;
                default: begin
                    if (m_cnt == m_len) begin
                        m_mode = 0;
                    end else if (recall_req) begin
                        exp_cv = 1;
                        exp_color = col_of(m_seq, m_cnt);
                        m_cnt++;
                        if (m_cnt == m_len) exp_done = 1;
                    end
                end
            endcase
            if (m_mode == 1) begin
                m_k++;
                if (m_k > m_len * P) begin
                    m_mode = 0; exp_done = 1; exp_led = '0;
                end else begin
                    exp_color = col_of(m_seq, (m_k - 1) / P);
                    exp_led = (((m_k - 1) % P) < ON) ? (4'b0001 << exp_color) : 4'b0000;
                end
            end
            exp_busy = (m_mode != 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("led", 32'(led), 32'(exp_led));
            check("color", 32'(color), 32'(exp_color));
            check("color_valid", 32'(color_valid), 32'(exp_cv));
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
        end
    end

    task automatic idle_inputs();
        seed_load = 0; play_start = 0; recall_start = 0; recall_req = 0;
    endtask

    // Starts a play pass and records led/done/busy for cycles 1..n after the start edge.
    logic [3:0] r_led[1:100];
    logic       r_done[1:100];
    logic       r_busy[1:100];
    task automatic run_play(input logic [31:0] s, input logic ld, input logic [4:0] lv, input int n);
        seed = s; seed_load = ld; level = lv; play_start = 1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            idle_inputs();
            r_led[k] = led; r_done[k] = done; r_busy[k] = busy;
        end
    endtask

    initial begin
        reset = 1; seed = '0; level = '0; idle_inputs();
        @(posedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        check("reset_led", 32'(led), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset = 0;
        @(negedge clk);

        // Seed E4E4E4E4 plays colours 0,1,2,3.
        run_play(32'hE4E4E4E4, 1, 5'd4, 26);
        check("t1_led_s0", 32'(r_led[1]), 32'h1);
        check("t1_off", 32'(r_led[5]), 32'h0);
        check("t1_led_s1", 32'(r_led[7]), 32'h2);
        check("t1_led_s2", 32'(r_led[13]), 32'h4);
        check("t1_led_s3", 32'(r_led[19]), 32'h8);
        check("t1_busy24", 32'(r_busy[24]), 32'h1);
        check("t1_done24", 32'(r_done[24]), 32'h0);
        check("t1_done25", 32'(r_done[25]), 32'h1);

        // Recall 4 back-to-back, with a 5th request landing in the done cycle.
        level = 5'd4; recall_start = 1;
        @(negedge clk);
        recall_start = 0; recall_req = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                check("t2_cv", 32'(color_valid), 32'h1);
                check("t2_color", 32'(color), 32'(i));
                check("t2_done", 32'(done), (i == 3) ? 32'h1 : 32'h0);
            end else begin
                check("t2_cv_after", 32'(color_valid), 32'h0);
                check("t2_busy_after", 32'(busy), 32'h0);
            end
        end
        idle_inputs();
        repeat (3) @(negedge clk);

        run_play(32'hE4E4E4E4, 0, 5'd0, 8);
        check("t3_len1_done", 32'(r_done[7]), 32'h1);
        run_play(32'hFFFFFFFF, 1, 5'd20, 98);
        check("t3_max_led1", 32'(r_led[1]), 32'h8);
        check("t3_max_led91", 32'(r_led[91]), 32'h8);
        check("t3_max_busy96", 32'(r_busy[96]), 32'h1);
        check("t3_max_done97", 32'(r_done[97]), 32'h1);

        // Both starts together; then extra play_start while ON.
        level = 5'd2; play_start = 1; recall_start = 1;
        @(negedge clk);
        idle_inputs(); recall_req = 1;
        @(negedge clk);
        play_start = 1;
        @(negedge clk);
        idle_inputs();
        repeat (14) @(negedge clk);

        // seed_load of 0 mid-play is ignored.
        seed = 32'h0000001B; seed_load = 1; level = 5'd3; play_start = 1;
        repeat (2) @(negedge clk);
        idle_inputs(); seed = 32'h0; seed_load = 1;
        @(negedge clk);
        idle_inputs();
        repeat (20) @(negedge clk);
        run_play(32'h0, 0, 5'd3, 20);
        check("t5_old_seed", 32'(r_led[1]), 32'h8);

        // Reset in the 3rd ON cycle of step 2 (cycle 9).
        seed = 32'h0000001B; seed_load = 1; level = 5'd4; play_start = 1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            idle_inputs();
        end
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("t6_led", 32'(led), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_done", 32'(done), 32'h0);
        run_play(32'hFFFFFFFF, 0, 5'd4, 26);
        check("t6_s1", 32'(r_led[7]), 32'h1);
        check("t6_s3", 32'(r_led[19]), 32'h1);

        for (int c = 0; c < 4000; c++) begin
            seed = $urandom;
            seed_load = ($urandom_range(0, 3) == 0);
            play_start = ($urandom_range(0, 15) == 0);
            recall_start = ($urandom_range(0, 11) == 0);
            recall_req = $urandom_range(0, 1) == 1;
            level = 5'($urandom_range(0, 20));
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset = 0; idle_inputs();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
